// File: rtl/ps2_uart_bridge.sv
// PS/2 scan-code to UART bridge: FIFO buffer plus a formatter that sends each byte
// raw or as uppercase hex text, with a sticky overflow flag and a saturating drop counter.
module ps2_uart_bridge #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_in_valid,
    input  logic [7:0]                 i_in_data,
    input  logic                       i_cfg_hex,
    input  logic                       i_clr_err,
    output logic                       o_tx_valid,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [CNT_W-1:0]           o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RAW, S_HI, S_LO, S_SEP, S_CR, S_LF} state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [7:0]       r_hold;
    state_t           r_state;

    logic w_push;
    logic w_pop;
    logic w_drop;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Fullness uses the registered level, so a pop in the same edge never frees room for a push.
    assign w_push = i_in_valid && (r_level != LW'(DEPTH));
    assign w_drop = i_in_valid && (r_level == LW'(DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop coinciding with clr_err restarts the count at one rather than clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clr_err)        r_drop_cnt <= CNT_W'(1);
            else if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end else if (i_clr_err) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_hold  <= r_mem[r_rptr];
                    r_state <= i_cfg_hex ? S_HI : S_RAW;
                end
                S_RAW:  if (i_tx_ready) r_state <= S_IDLE;
                S_HI:   if (i_tx_ready) r_state <= S_LO;
                S_LO:   if (i_tx_ready)
                    r_state <= (r_hold == 8'hE0 || r_hold == 8'hF0) ? S_SEP : S_CR;
                S_SEP:  if (i_tx_ready) r_state <= S_IDLE;
                S_CR:   if (i_tx_ready) r_state <= S_LF;
                S_LF:   if (i_tx_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_tx_data = 8'h00;
        case (r_state)
            S_RAW: o_tx_data = r_hold;
            S_HI:  o_tx_data = f_hex(r_hold[7:4]);
            S_LO:  o_tx_data = f_hex(r_hold[3:0]);
            S_SEP: o_tx_data = 8'h20;
            S_CR:  o_tx_data = 8'h0D;
            S_LF:  o_tx_data = 8'h0A;
            default: o_tx_data = 8'h00;
        endcase
    end

    assign o_tx_valid = (r_state != S_IDLE);
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;
endmodule
